// File: rtl/fetch_prefetch_if.sv
// Fetch-stage bus bundle: instruction-memory request/response plus decode-side output.
// master = fetch stage (drives requests and the buffered instruction stream).
// slave  = memory + decode side (drives responses and the consumer ready).
interface fetch_prefetch_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  // Instruction memory: request held until mem_done, error qualified by mem_done
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_done;
  logic [DATA_W-1:0] mem_data;
  logic              mem_err;

  // Prefetch buffer head towards decode: valid/ready
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;
  logic [ADDR_W-1:0] out_pc_next;
  logic              out_err;

  modport master (
    output mem_rd, mem_addr,
    input  mem_done, mem_data, mem_err,
    output out_valid, out_instr, out_pc, out_pc_next, out_err,
    input  out_ready
  );

  modport slave (
    input  mem_rd, mem_addr,
    output mem_done, mem_data, mem_err,
    input  out_valid, out_instr, out_pc, out_pc_next, out_err,
    output out_ready
  );
endinterface

// File: rtl/fetch_prefetch.sv
// Fetch stage: owns the PC, issues reads to a stalling imem, buffers replies in a DEPTH-entry FIFO.
// Latency: redirect at t -> request at t+1; mem_done at d -> out_valid at d+1 (never combinational).
// Backpressure: a request issues only with a FIFO slot reserved; consumer pops on out_valid&out_ready.
// Optional build macro FETCH_PERF_EN adds saturating stall-cycle and flush counters.
module fetch_prefetch #(
  parameter int              ADDR_W   = 16,
  parameter int              DATA_W   = 16,
  parameter int              DEPTH    = 4,
  parameter int              INC      = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 halt,
  input  logic                 redirect_valid,
  input  logic [ADDR_W-1:0]    redirect_pc,
  fetch_prefetch_if.master     bus,
  output logic                 halted
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]          perf_stall_cyc,
  output logic [15:0]          perf_flush_cnt
`endif
);

  localparam int                PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(INC);
  localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [DATA_W-1:0] instr;
    logic              err;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    DROP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] drop_addr_q, drop_addr_d;
  logic              halt_seen_q, halt_seen_d;

  entry_t            buf_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic              redir_acc;
  logic              halt_now;
  logic              push;
  logic              pop;
  logic              flush;
  logic              head_vld;
  logic              space_ok;
  logic              rd_active;
  logic [CNT_W-1:0]  count_after;
  entry_t            push_dat;
  entry_t            head;

  // Redirect is ignored once halted; a same-cycle halt already blocks new requests.
  assign redir_acc   = redirect_valid && (state_q != HALTED);
  assign halt_now    = halt_seen_q || halt;
  assign head_vld    = (count_q != '0);
  // A response that coincides with an accepted redirect belongs to the old stream.
  assign push        = (state_q == REQ) && bus.mem_done && !redir_acc;
  // Flush wins over a same-cycle pop.
  assign pop         = head_vld && bus.out_ready && !redir_acc;
  assign count_after = count_q + CNT_W'(push) - CNT_W'(pop);
  // Space for the next request must already exist once this cycle's push/pop settle.
  assign space_ok    = (count_after < DEPTH_C);
  assign rd_active   = (state_q == REQ) || (state_q == DROP);

  always_comb begin
    push_dat       = '0;
    push_dat.pc    = pc_q;
    push_dat.instr = bus.mem_data;
    push_dat.err   = bus.mem_err;
  end

  // Fetch FSM: next state, PC, address held for a discarded request, halt latch
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    halt_seen_d = halt_seen_q || halt;
    flush       = 1'b0;
    case (state_q)
      IDLE: begin
        if (redir_acc) begin
          flush   = 1'b1;
          pc_d    = redirect_pc;
          state_d = halt_now ? HALTED : REQ;
        end else if (halt_now) begin
          state_d = HALTED;
        end else if (count_q < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (redir_acc) begin
          flush = 1'b1;
          pc_d  = redirect_pc;
          if (bus.mem_done) begin
            // Response dropped; the new stream starts right away.
            state_d = halt_now ? HALTED : REQ;
          end else begin
            // Bus must keep the old address until the memory answers.
            drop_addr_d = pc_q;
            state_d     = DROP;
          end
        end else if (bus.mem_done) begin
          pc_d = pc_q + INC_C;
          if (halt_now || bus.mem_err) begin
            state_d = HALTED;
          end else begin
            state_d = space_ok ? REQ : IDLE;
          end
        end
      end
      DROP: begin
        if (redir_acc) begin
          pc_d = redirect_pc;
        end
        if (bus.mem_done) begin
          if (halt_now) begin
            state_d = HALTED;
          end else begin
            state_d = space_ok ? REQ : IDLE;
          end
        end
      end
      default: begin
        state_d = HALTED;
      end
    endcase
  end

  // Prefetch FIFO pointers and occupancy; a flush empties it in one cycle
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      count_d = count_after;
    end
  end

  // State, PC and FIFO control registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      drop_addr_q <= '0;
      halt_seen_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      halt_seen_q <= halt_seen_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage; written only on an accepted response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else if (push) begin
      buf_q[wr_ptr_q] <= push_dat;
    end
  end

  assign head = buf_q[rd_ptr_q];

  // Outputs: data fields read as zero whenever the head is not valid
  assign bus.mem_rd      = rd_active;
  assign bus.mem_addr    = (state_q == REQ)  ? pc_q :
                           (state_q == DROP) ? drop_addr_q : '0;
  assign bus.out_valid   = head_vld;
  assign bus.out_instr   = head_vld ? head.instr : '0;
  assign bus.out_pc      = head_vld ? head.pc : '0;
  assign bus.out_pc_next = head_vld ? (head.pc + INC_C) : '0;
  assign bus.out_err     = head_vld && head.err;
  assign halted          = (state_q == HALTED);

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cyc_q, stall_cyc_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;

  // Saturating counters: memory stall cycles and accepted redirects
  always_comb begin
    stall_cyc_d = stall_cyc_q;
    flush_cnt_d = flush_cnt_q;
    if (rd_active && !bus.mem_done && (stall_cyc_q != '1)) begin
      stall_cyc_d = stall_cyc_q + 32'd1;
    end
    if (redir_acc && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 16'd1;
    end
  end

  // Performance counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cyc_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cyc_q <= stall_cyc_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign perf_stall_cyc = stall_cyc_q;
  assign perf_flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch.sv
// Bench for fetch_prefetch: directed steps, then random redirect/backpressure/latency traffic.
// A stream model checks every head entry: consecutive PCs from the last accepted redirect.
// The memory responder derives data from the address, so every entry is self-describing.
module tb_fetch_prefetch;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          halt = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic          halted;

  int            total = 0;
  int            bad   = 0;
  int            lat = 1;
  bit            lat_rand = 1'b0;
  bit            err_en = 1'b0;
  logic [AW-1:0] err_addr = '0;
  logic [AW-1:0] pop_log[$];
  logic [AW-1:0] req_log[$];

  fetch_prefetch_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cyc;
  logic [15:0] perf_flush_cnt;
`endif

  fetch_prefetch #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .INC(2), .RESET_PC(16'h0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus.master),
    .halted         (halted)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cyc (perf_stall_cyc),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] instr_of(input logic [AW-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Memory responder: answers after cur_lat wait cycles, data derived from the address.
  initial begin
    int wcnt;
    int cur_lat;
    wcnt = 0;
    cur_lat = 1;
    bus.mem_done = 1'b0;
    bus.mem_data = '0;
    bus.mem_err  = 1'b0;
    forever begin
      @(negedge clk);
      bus.mem_done = 1'b0;
      bus.mem_err  = 1'b0;
      if (bus.mem_rd === 1'b1) begin
        if (wcnt >= cur_lat) begin
          bus.mem_done = 1'b1;
          bus.mem_data = instr_of(bus.mem_addr);
          bus.mem_err  = err_en && (bus.mem_addr == err_addr);
          wcnt = 0;
          cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
        cur_lat = lat_rand ? int'($urandom_range(0, 3)) : lat;
      end
    end
  end

  // Stream model: occupancy, head PC, pending discarded response; sampled 1 unit before posedge.
  initial begin
    int            occ;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] tail_pc;
    bit            drop_pend;
    bit            redir_acc, done_req, pop, push;
    occ = 0;
    exp_pc = '0;
    drop_pend = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      if (!rst) begin
        occ = 0;
        exp_pc = 16'h0000;
        drop_pend = 1'b0;
        pop_log.delete();
        req_log.delete();
        continue;
      end
      chk("valid_vs_model", {31'd0, bus.out_valid}, {31'd0, occ != 0});
      if (bus.out_valid) begin
        chk("head_pc", {16'd0, bus.out_pc}, {16'd0, exp_pc});
        chk("head_instr", {16'd0, bus.out_instr}, {16'd0, instr_of(exp_pc)});
        tail_pc = exp_pc + 16'd2;
        chk("head_pc_next", {16'd0, bus.out_pc_next}, {16'd0, tail_pc});
        chk("head_err", {31'd0, bus.out_err}, {31'd0, err_en && (exp_pc == err_addr)});
      end
      chk("space_reserved",
          {31'd0, (occ + ((bus.mem_rd && !drop_pend) ? 1 : 0)) <= DEPTH}, 32'd1);
      redir_acc = redirect_valid && !halted;
      done_req  = bus.mem_rd && bus.mem_done;
      pop       = bus.out_valid && bus.out_ready && !redir_acc;
      push      = done_req && !redir_acc && !drop_pend;
      if (push) begin
        tail_pc = exp_pc + 16'(2 * occ);
        chk("push_addr", {16'd0, bus.mem_addr}, {16'd0, tail_pc});
      end
      if (pop) pop_log.push_back(bus.out_pc);
      if (done_req) req_log.push_back(bus.mem_addr);
      if (drop_pend) begin
        if (done_req) drop_pend = 1'b0;
      end else if (redir_acc && bus.mem_rd && !bus.mem_done) begin
        drop_pend = 1'b1;
      end
      if (redir_acc) begin
        occ = 0;
        exp_pc = redirect_pc;
      end else begin
        occ = occ + (push ? 1 : 0) - (pop ? 1 : 0);
        if (pop) exp_pc = exp_pc + 16'd2;
      end
    end
  end

  // Reset for two cycles, optionally holding a redirect across release; returns one cycle after release.
  task automatic do_reset(input logic rv, input logic [AW-1:0] rpc);
    rst = 1'b0;
    halt = 1'b0;
    redirect_valid = rv;
    redirect_pc = rpc;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int k;
    int n10;
    bus.out_ready = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_out_instr", {16'd0, bus.out_instr}, 32'd0);
    chk("rst_out_pc", {16'd0, bus.out_pc}, 32'd0);
    chk("rst_out_pc_next", {16'd0, bus.out_pc_next}, 32'd0);

    // Sequential fetch from RESET_PC, one wait cycle per request
    lat = 1;
    do_reset(1'b0, '0);
    repeat (20) @(negedge clk);
    chk("seq_req0", {16'd0, req_log[0]}, 32'h0000);
    chk("seq_req1", {16'd0, req_log[1]}, 32'h0002);
    chk("seq_req2", {16'd0, req_log[2]}, 32'h0004);
    chk("seq_pop0", {16'd0, pop_log[0]}, 32'h0000);
    chk("seq_pop2", {16'd0, pop_log[2]}, 32'h0004);

    // Consumer stalled: exactly DEPTH responses, then drain in order and resume
    bus.out_ready = 1'b0;
    do_reset(1'b0, '0);
    repeat (30) @(negedge clk);
    chk("full_req_count", req_log.size(), DEPTH);
    chk("full_mem_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("full_valid", {31'd0, bus.out_valid}, 32'd1);
    bus.out_ready = 1'b1;
    repeat (30) @(negedge clk);
    for (int i = 0; i < 4; i++) chk("drain_pop", {16'd0, pop_log[i]}, 32'(2 * i));
    chk("resume_req", {16'd0, req_log[4]}, 32'h0008);

    // Redirect during a stalled request: old response discarded
    lat = 3;
    do_reset(1'b1, 16'h0010);
    chk("redir_lat_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("redir_lat_addr", {16'd0, bus.mem_addr}, 32'h0010);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0040;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("drop_hold_addr", {16'd0, bus.mem_addr}, 32'h0010);
    chk("drop_empty", {31'd0, bus.out_valid}, 32'd0);
    k = 0;
    while (!(bus.mem_rd && bus.mem_addr != 16'h0010) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("drop_next_addr", {16'd0, bus.mem_addr}, 32'h0040);
    repeat (20) @(negedge clk);
    chk("drop_first_pop", {16'd0, pop_log[0]}, 32'h0040);
    n10 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 16'h0010) n10++;
    chk("drop_never_seen", n10, 0);

    // Redirect coinciding with mem_done
    lat = 0;
    do_reset(1'b0, '0);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0080;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("same_cyc_rd", {31'd0, bus.mem_rd}, 32'd1);
    chk("same_cyc_addr", {16'd0, bus.mem_addr}, 32'h0080);
    chk("same_cyc_empty", {31'd0, bus.out_valid}, 32'd0);
    repeat (10) @(negedge clk);
    chk("same_cyc_pop0", {16'd0, pop_log[0]}, 32'h0080);

    // Halt during an in-flight request
    lat = 3;
    do_reset(1'b1, 16'h0020);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    k = 0;
    while (!halted && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (5) @(negedge clk);
    chk("halt_flag", {31'd0, halted}, 32'd1);
    chk("halt_pop_count", pop_log.size(), 1);
    chk("halt_pop0", {16'd0, pop_log[0]}, 32'h0020);
    redirect_valid = 1'b1;
    redirect_pc = 16'h0100;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("halt_ignores_redir_rd", {31'd0, bus.mem_rd}, 32'd0);
    chk("halt_sticky", {31'd0, halted}, 32'd1);
    chk("halt_req_count", req_log.size(), 1);

    // Memory error stops fetch, entry carries the flag
    lat = 1;
    err_en = 1'b1;
    err_addr = 16'h0030;
    bus.out_ready = 1'b0;
    do_reset(1'b1, 16'h0030);
    k = 0;
    while (!halted && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("err_halted", {31'd0, halted}, 32'd1);
    chk("err_valid", {31'd0, bus.out_valid}, 32'd1);
    chk("err_flag", {31'd0, bus.out_err}, 32'd1);
    chk("err_pc", {16'd0, bus.out_pc}, 32'h0030);
    chk("err_no_rd", {31'd0, bus.mem_rd}, 32'd0);
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    err_en = 1'b0;

    // Asynchronous reset in the middle of a request
    lat = 5;
    do_reset(1'b0, '0);
    chk("mid_rst_pre_rd", {31'd0, bus.mem_rd}, 32'd1);
    #3;
    rst = 1'b0;
    #1;
    chk("mid_rst_rd_async", {31'd0, bus.mem_rd}, 32'd0);
    chk("mid_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    rst = 1'b1;
    k = 0;
    while (!bus.mem_rd && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("mid_rst_restart_addr", {16'd0, bus.mem_addr}, 32'h0000);

    // Random traffic: latency, backpressure, redirects (including near the wrap point)
    lat_rand = 1'b1;
    do_reset(1'b0, '0);
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) redirect_pc = 16'hFFFA;
      else redirect_pc = 16'($urandom) & 16'hFFFE;
    end
    @(negedge clk);
    redirect_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(negedge clk);
    chk("rand_progress", {31'd0, pop_log.size() > 100}, 32'd1);
    chk("rand_not_halted", {31'd0, halted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
